// File: rtl/ov7670_stream_source.sv
// OV7670-compatible camera stream source: drives pclk/vsync/href and an RGB565
// byte stream carrying a selectable test pattern, framed like a physical sensor.
module ov7670_stream_source #(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam int ACT_SLOTS  = 2 * IMG_WIDTH;
  localparam int LINE_SLOTS = ACT_SLOTS + H_BLANK;
  localparam int BAR_PIX    = IMG_WIDTH / 8;
  localparam int SW         = $clog2(LINE_SLOTS);
  localparam int LW         = $clog2(VSYNC_LINES + V_BACK + IMG_HEIGHT + V_FRONT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [LW-1:0] line_q, line_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   solid_q, solid_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q;
  logic [7:0]    frame_cnt_q;

  logic [LW-1:0] line_last_s;
  logic          line_end_s;
  logic          state_end_s;
  logic          frame_end_s;
  logic [15:0]   x_s;
  logic          y3_s;
  logic [15:0]   pix_s;

  function automatic logic [15:0] pattern_pixel(
    input logic [1:0]  sel,
    input logic [15:0] solid,
    input logic [15:0] x,
    input logic        y3,
    input logic        odd_frame
  );
    logic [2:0]  bar;
    logic [7:0]  g;
    logic [15:0] pix;
    bar = 3'(x / 16'(BAR_PIX));
    g   = x[7:0];
    case (sel)
      2'd0: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = solid;
      2'd2:    pix = {g[7:3], g[7:2], g[7:3]};
      default: pix = (x[3] ^ y3 ^ odd_frame) ? 16'hFFFF : 16'h0000;
    endcase
    return pix;
  endfunction

  // Number of line periods spent in the current state, minus one.
  always_comb begin
    case (state_q)
      S_VSYNC:  line_last_s = LW'(VSYNC_LINES - 1);
      S_VBACK:  line_last_s = LW'(V_BACK - 1);
      S_ACTIVE: line_last_s = LW'(IMG_HEIGHT - 1);
      S_VFRONT: line_last_s = LW'(V_FRONT - 1);
      default:  line_last_s = LW'(0);
    endcase
  end

  assign line_end_s  = (slot_q == SW'(LINE_SLOTS - 1));
  assign state_end_s = (line_q == line_last_s);
  assign frame_end_s = (state_q == S_VFRONT) && line_end_s && state_end_s;

  // Position and state of the slot that starts at the next pclk falling edge.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    line_d  = line_q;
    sel_d   = sel_q;
    solid_d = solid_q;
    if (state_q == S_IDLE) begin
      slot_d = SW'(0);
      line_d = LW'(0);
      if (en) begin
        state_d = S_VSYNC;
        sel_d   = pattern_sel;
        solid_d = solid_rgb565;
      end else begin
        state_d = S_IDLE;
      end
    end else if (!line_end_s) begin
      slot_d = slot_q + SW'(1);
    end else if (!state_end_s) begin
      slot_d = SW'(0);
      line_d = line_q + LW'(1);
    end else begin
      slot_d = SW'(0);
      line_d = LW'(0);
      case (state_q)
        S_VSYNC:  state_d = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
        S_VBACK:  state_d = S_ACTIVE;
        S_ACTIVE: state_d = S_VFRONT;
        S_VFRONT: begin
          if (en) begin
            state_d = S_VSYNC;
            sel_d   = pattern_sel;
            solid_d = solid_rgb565;
          end else begin
            state_d = S_IDLE;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output values for the upcoming slot; the pattern uses the per-frame latched settings.
  always_comb begin
    x_s     = 16'(slot_d >> 1);
    y3_s    = ((32'(line_d) >> 3) & 32'd1) != 32'd0;
    pix_s   = pattern_pixel(sel_q, solid_q, x_s, y3_s, frame_cnt_q[0]);
    vsync_d = (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    href_d  = (state_d == S_ACTIVE) && (slot_d < SW'(ACT_SLOTS));
    data_d  = href_d ? (slot_d[0] ? pix_s[7:0] : pix_s[15:8]) : 8'h00;
  end

  // Phase 0 -> 1 edge: frame completion bookkeeping; phase 1 -> 0 edge: advance one slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      slot_q       <= SW'(0);
      line_q       <= LW'(0);
      sel_q        <= 2'd0;
      solid_q      <= 16'h0000;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      phase_q      <= ~phase_q;
      frame_done_q <= 1'b0;
      if (!phase_q) begin
        if (frame_end_s) begin
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
        end
      end else begin
        state_q <= state_d;
        slot_q  <= slot_d;
        line_q  <= line_d;
        sel_q   <= sel_d;
        solid_q <= solid_d;
        vsync_q <= vsync_d;
        href_q  <= href_d;
        data_q  <= data_d;
        busy_q  <= busy_d;
      end
    end
  end

  assign cam_pclk   = phase_q;
  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_stream_source.sv
// Self-checking bench for ov7670_stream_source using a small frame geometry and
// a slot-indexed reference model of the expected pin activity.
module tb_ov7670_stream_source;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int LINE  = 2 * W + HB;
  localparam int FRAME = (VS + VB + H + VF) * LINE;
  localparam int MID   = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb565 = 16'h0000;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ov7670_stream_source #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pattern_sel(pattern_sel),
    .solid_rgb565(solid_rgb565), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  function automatic logic [15:0] ref_pix(input int sel, input logic [15:0] solid,
                                          input int x, input int y, input int fc);
    logic [15:0] bars [8];
    int g;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (sel)
      0: return bars[x / (W / 8)];
      1: return solid;
      2: begin
        g = x % 256;
        return 16'((g / 8) * 2048 + (g / 4) * 32 + (g / 8));
      end
      default: return ((((x / 8) + (y / 8) + fc) % 2) == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Expected {pclk, busy, vsync, href, frame_done, frame_cnt, data} for slot s, half h.
  function automatic logic [20:0] ref_slot(input int s, input int h, input int sel,
                                           input logic [15:0] solid, input int fc);
    int line, col;
    logic vs, hr, fd;
    logic [15:0] p;
    logic [7:0] d;
    line = s / LINE;
    col  = s % LINE;
    vs   = (line < VS);
    hr   = (line >= VS + VB) && (line < VS + VB + H) && (col < 2 * W);
    d    = 8'h00;
    if (hr) begin
      p = ref_pix(sel, solid, col / 2, line - VS - VB, fc);
      d = ((col % 2) == 0) ? p[15:8] : p[7:0];
    end
    fd = (s == FRAME - 1) && (h == 1);
    return {1'(h), 1'b1, vs, hr, fd, 8'(fc + (fd ? 1 : 0)), d};
  endfunction

  task automatic capture_frame(input int sel, input logic [15:0] solid, input int fc,
                               input int nsel, input logic [15:0] nsolid, input bit nen,
                               input string name);
    int n;
    logic [20:0] act, exp;
    n = 0;
    while (cam_vsync !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cam_vsync !== 1'b1) begin
      $display("FAIL %s frame start: vsync=%b after %0d clk, required 1", name, cam_vsync, n);
      miscompares++;
      return;
    end
    for (int s = 0; s < FRAME; s++) begin
      for (int h = 0; h < 2; h++) begin
        act = {cam_pclk, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
        exp = ref_slot(s, h, sel, solid, fc);
        vectors++;
        if (act !== exp) begin
          $display("FAIL %s slot %0d half %0d: got %h, required %h", name, s, h, act, exp);
          miscompares++;
        end
        @(negedge clk);
      end
      if (s == MID) begin
        pattern_sel  = 2'(nsel);
        solid_rgb565 = nsolid;
        en           = nen;
      end
    end
    act = {cam_pclk, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
    exp = {1'b0, nen, nen, 1'b0, 1'b0, 8'(fc + 1), 8'h00};
    vectors++;
    if (act !== exp) begin
      $display("FAIL %s post-frame: got %h, required %h", name, act, exp);
      miscompares++;
    end
  endtask

  task automatic check_idle(input int cycles, input logic [7:0] cnt, input string name);
    logic prev;
    logic [19:0] act, exp;
    prev = cam_pclk;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      act = {~prev, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
      exp = {cam_pclk, 1'b0, 1'b0, 1'b0, 1'b0, cnt, 8'h00};
      vectors++;
      if (act !== exp) begin
        $display("FAIL %s clk %0d: got %h, required %h", name, i, act, exp);
        miscompares++;
      end
      prev = cam_pclk;
    end
  endtask

  task automatic test_reset;
    logic [19:0] act;
    reset = 1'b0;
    en    = 1'b0;
    repeat (4) @(negedge clk);
    act = {cam_pclk, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
    vectors++;
    if (act !== 20'h0) begin
      $display("FAIL reset_state: got %h, required %h", act, 20'h0);
      miscompares++;
    end
    reset = 1'b1;
  endtask

  task automatic test_idle;
    check_idle(1000, 8'd0, "idle_en_low");
  endtask

  task automatic test_color_bars;
    pattern_sel = 2'd0;
    en = 1'b1;
    capture_frame(0, 16'h0000, 0, 1, 16'hA5C3, 1'b1, "color_bars");
  endtask

  task automatic test_solid_change;
    capture_frame(1, 16'hA5C3, 1, 1, 16'h1234, 1'b1, "solid_A5C3");
    capture_frame(1, 16'h1234, 2, 2, 16'h0000, 1'b1, "solid_1234");
  endtask

  task automatic test_back_to_back;
    int rs, rs2;
    logic [15:0] rc, rc2;
    rs  = int'($urandom_range(0, 3));
    rc  = 16'($urandom);
    rs2 = int'($urandom_range(0, 3));
    rc2 = 16'($urandom);
    capture_frame(2, 16'h0000, 3, rs, rc, 1'b1, "gray_ramp");
    capture_frame(rs, rc, 4, rs2, rc2, 1'b0, "random_en_drop");
  endtask

  task automatic test_en_drop;
    check_idle(200, 8'd5, "idle_after_drop");
  endtask

  task automatic test_reset_mid_frame;
    int n;
    logic [19:0] act;
    pattern_sel  = 2'($urandom_range(0, 3));
    solid_rgb565 = 16'($urandom);
    en = 1'b1;
    n = 0;
    while (cam_href !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cam_href !== 1'b1) begin
      $display("FAIL reset_mid wait href: href=%b, required 1", cam_href);
      miscompares++;
    end
    #2 reset = 1'b0;
    #1;
    act = {cam_pclk, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
    vectors++;
    if (act !== 20'h0) begin
      $display("FAIL reset_mid immediate: got %h, required %h", act, 20'h0);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    act = {cam_pclk, busy, cam_vsync, cam_href, frame_done, frame_cnt, cam_data};
    vectors++;
    if (act !== 20'h0) begin
      $display("FAIL reset_mid held: got %h, required %h", act, 20'h0);
      miscompares++;
    end
    pattern_sel = 2'd3;
    reset = 1'b1;
    capture_frame(3, 16'h0000, 0, 3, 16'h0000, 1'b1, "checker_f0");
    capture_frame(3, 16'h0000, 1, 0, 16'h0000, 1'b0, "checker_f1");
    check_idle(100, 8'd2, "idle_after_checker");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_color_bars();
    test_solid_change();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
